divu_iter: RTL and testbench

// - Iterative 32-bit unsigned divider for the MIPS54 CPU multiply/divide unit; executes DIVU.
// - Radix-2 restoring division, one quotient bit per clock, start/busy/done handshake.
// - Sits beside the combinational multiplier; the pipeline stalls on busy and writes q/r to LO/HI on done.

---
 rtl/divu_iter.sv | 148 ++++++++++++++
 tb/tb_divu_iter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_iter.sv
// Iterative radix-2 restoring divider (DIVU), one quotient bit per clock.
// Define DIVU_ITER_SIGNED_EN to add the `sgn` input for signed DIV support.
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DIVU_ITER_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic             zero_q;
    logic [WIDTH-1:0] q_res_q;
    logic [WIDTH-1:0] r_res_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    always_comb begin
        shifted = {acc_q, sh_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        acc_d   = shifted[WIDTH-1:0];
        sh_d    = {sh_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            acc_d = trial[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end
    end

`ifdef DIVU_ITER_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;

    always_comb begin
        dvd_mag = (sgn && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
        dvs_mag = (sgn && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
        q_fin   = neg_q_q ? (~sh_d + 1'b1)  : sh_d;
        r_fin   = neg_r_q ? (~acc_d + 1'b1) : acc_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (start && (state_q != S_RUN)) begin
            neg_q_q <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_q <= sgn && dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_fin   = sh_d;
        r_fin   = acc_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            zero_q  <= 1'b0;
            q_res_q <= '0;
            r_res_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        sh_q    <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        dvd_q   <= dividend;
                        zero_q  <= (divisor == '0);
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Results become visible only on the final iteration edge.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dz_q    <= zero_q;
                        q_res_q <= zero_q ? '1 : q_fin;
                        r_res_q <= zero_q ? dvd_q : r_fin;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q    = q_res_q;
    assign r    = r_res_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_divu_iter.sv
// Randomised self-checking bench for divu_iter against an arithmetic reference.
// Signed cases are exercised when DIVU_ITER_SIGNED_EN is defined.
module tb_divu_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dz;
`ifdef DIVU_ITER_SIGNED_EN
    logic        sgn_r;
`endif

    int checks = 0;
    int errors = 0;

    divu_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef DIVU_ITER_SIGNED_EN
        .sgn      (sgn_r),
`endif
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] rq, output logic [31:0] rr);
        longint sa;
        longint sb;
        longint x;
        longint y;
        if (b == 32'd0) begin
            rq = 32'hFFFFFFFF;
            rr = a;
        end else if (!s) begin
            rq = a / b;
            rr = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            x  = sa / sb;
            y  = sa % sb;
            rq = x[31:0];
            rr = y[31:0];
        end
    endfunction

    // Launch one operation from the current (post-edge) time and wait for done.
    // Returns with time just after the done edge, start deasserted.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] gq, output logic [31:0] gr, output logic gdz,
                          output int cyc, output int bcnt, output logic tmo);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIVU_ITER_SIGNED_EN
        sgn_r    = s;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        bcnt  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        tmo = (done !== 1'b1);
        gq  = q;
        gr  = r;
        gdz = dz;
        $display("op %08h / %08h sgn=%0d -> q=%08h r=%08h dz=%0d after %0d cycles", a, b, s, gq, gr, gdz, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q, r, busy, done, dz} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: q=%08h r=%08h busy=%0b done=%0b dz=%0b, required all zero", q, r, busy, done, dz);
        end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_latency();
        logic [31:0] gq, gr;
        logic gdz, tmo;
        int cyc, bcnt;
        run_op(32'd100, 32'd7, 1'b0, gq, gr, gdz, cyc, bcnt, tmo);
        checks++;
        if (tmo !== 1'b0 || cyc != 32) begin
            errors++;
            $display("FAIL latency: done after %0d cycles (timeout=%0b), required 32", cyc, tmo);
        end
        checks++;
        if (bcnt != 32 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_span: busy high %0d cycles, busy at done=%0b, required 32 and 0", bcnt, busy);
        end
        checks++;
        if (gq !== 32'd14 || gr !== 32'd2 || gdz !== 1'b0) begin
            errors++;
            $display("FAIL result_100_7: q=%0d r=%0d dz=%0b, required q=14 r=2 dz=0", gq, gr, gdz);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || q !== 32'd14 || r !== 32'd2) begin
            errors++;
            $display("FAIL done_pulse: done=%0b q=%0d r=%0d one cycle later, required done=0 q=14 r=2", done, q, r);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'd0, 32'h12345678};
        logic [31:0] tb [5] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'd1};
        logic [31:0] gq, gr, eq, er;
        logic gdz, tmo;
        int cyc, bcnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            run_op(ta[i], tb[i], 1'b0, gq, gr, gdz, cyc, bcnt, tmo);
            ref_div(ta[i], tb[i], 1'b0, eq, er);
            checks++;
            if (tmo || gq !== eq || gr !== er || gdz !== 1'b0) begin
                errors++;
                $display("FAIL boundary_%0d: q=%08h r=%08h dz=%0b tmo=%0b, required q=%08h r=%08h dz=0", i, gq, gr, gdz, tmo, eq, er);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] gq, gr;
        logic gdz, tmo;
        int cyc, bcnt;
        @(posedge clk); #1;
        run_op(32'd5, 32'd0, 1'b0, gq, gr, gdz, cyc, bcnt, tmo);
        checks++;
        if (tmo || cyc != 32 || gq !== 32'hFFFFFFFF || gr !== 32'd5 || gdz !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: q=%08h r=%08h dz=%0b cycles=%0d, required q=ffffffff r=5 dz=1 cycles=32", gq, gr, gdz, cyc);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dz !== 1'b1 || q !== 32'hFFFFFFFF || r !== 32'd5) begin
            errors++;
            $display("FAIL div_zero_hold: q=%08h r=%08h dz=%0b, required held ffffffff/5/1", q, r, dz);
        end
        run_op(32'd6, 32'd3, 1'b0, gq, gr, gdz, cyc, bcnt, tmo);
        checks++;
        if (tmo || gq !== 32'd2 || gr !== 32'd0 || gdz !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: q=%0d r=%0d dz=%0b, required q=2 r=0 dz=0", gq, gr, gdz);
        end
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        int done_at = -1;
        logic [31:0] gq = '0;
        logic [31:0] gr = '0;
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (cyc == 10) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                done_at = cyc;
                gq = q;
                gr = r;
            end
            @(posedge clk); #1;
        end
        $display("op 1000/3 with ignored start -> q=%0d r=%0d pulses=%0d at %0d", gq, gr, pulses, done_at);
        checks++;
        if (pulses != 1 || done_at != 32 || gq !== 32'd333 || gr !== 32'd1) begin
            errors++;
            $display("FAIL ignored_start: pulses=%0d at=%0d q=%0d r=%0d, required 1 at 32 q=333 r=1", pulses, done_at, gq, gr);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        logic [31:0] gq, gr;
        logic gdz, tmo;
        int cyc, bcnt;
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 32'd0 || r !== 32'd0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%0b done=%0b q=%0d r=%0d dz=%0b, required all zero", busy, done, q, r, dz);
        end
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses after abort, required 0", pulses);
        end
        run_op(32'd50, 32'd5, 1'b0, gq, gr, gdz, cyc, bcnt, tmo);
        checks++;
        if (tmo || gq !== 32'd10 || gr !== 32'd0) begin
            errors++;
            $display("FAIL after_abort: q=%0d r=%0d, required q=10 r=0", gq, gr);
        end
    endtask

    // Consecutive run_op calls issue start in the done cycle, so every
    // operation after the first is a back-to-back accept.
    task automatic test_back_to_back(input bit use_sgn);
        logic [31:0] a, b, gq, gr, eq, er;
        logic gdz, tmo, s;
        int cyc, bcnt;
        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = (i % 6 == 0) ? 32'd0 : $urandom_range(1, 65535);
                default: begin b = $urandom; a = b * $urandom_range(0, 3); end
            endcase
            s = use_sgn ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(a, b, s, gq, gr, gdz, cyc, bcnt, tmo);
            ref_div(a, b, s, eq, er);
            checks++;
            if (tmo || cyc != 32 || gq !== eq || gr !== er || gdz !== (b == 32'd0)) begin
                errors++;
                $display("FAIL random_%0d: %08h/%08h sgn=%0d got q=%08h r=%08h dz=%0b cyc=%0d, required q=%08h r=%08h dz=%0b cyc=32",
                         i, a, b, s, gq, gr, gdz, cyc, eq, er, (b == 32'd0));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: done=%0b busy=%0b, required 0 0", done, busy);
        end
    endtask

`ifdef DIVU_ITER_SIGNED_EN
    task automatic test_signed();
        logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFB};
        logic [31:0] tb [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0};
        logic [31:0] xq [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] xr [4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFB};
        logic [31:0] gq, gr;
        logic gdz, tmo;
        int cyc, bcnt;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 1'b1, gq, gr, gdz, cyc, bcnt, tmo);
            checks++;
            if (tmo || cyc != 32 || gq !== xq[i] || gr !== xr[i] || gdz !== (i == 3)) begin
                errors++;
                $display("FAIL signed_%0d: q=%08h r=%08h dz=%0b cyc=%0d, required q=%08h r=%08h", i, gq, gr, gdz, cyc, xq[i], xr[i]);
            end
        end
        test_back_to_back(1'b1);
    endtask
`endif

    initial begin
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset    = 1'b0;
`ifdef DIVU_ITER_SIGNED_EN
        sgn_r    = 1'b0;
`endif
        test_reset();
        test_latency();
        test_boundary();
        test_div_zero();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back(1'b0);
`ifdef DIVU_ITER_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
